score_bcd_display: RTL
======================

// Module: score_bcd_display
// PURPOSE
//  Sequential binary-to-BCD converter (shift-add-3, one bit per clock) between the
//  jump logic's 20-bit Score and the HexDriver digit instances. Samples Score on a
//  frame tick or an explicit start and converts it to six BCD digits. Presents those
//  digits with a leading-zero blank mask so the HEX display shows a stable,
//  frame-coherent score.
// PARAMETERS
//  SCORE_W  20  width of Score input; also number of SHIFT cycles
//  DIGITS   6   BCD digits produced; saturation value = 10^DIGITS-1 (999999)
// PORTS
//  Clk        in   1          system clock (MAX10_CLK1_50 domain)
//  Reset_n    in   1          asynchronous, active-low reset
//  frame_clk  in   1          VGA vsync; asynchronous to Clk, rising edge = request
//  start      in   1          synchronous single-cycle conversion request
//  Score      in   SCORE_W    unsigned binary score
//  bcd        out  4*DIGITS   digit i in bcd[4i+3:4i]; digit 0 = units
//  blank      out  DIGITS     1 = digit i is a leading zero (suppress on display)
//  overflow   out  1          last converted Score exceeded 10^DIGITS-1
//  busy       out  1          conversion in progress (state != IDLE)
//  done       out  1          one-cycle pulse when bcd/blank/overflow update
// BEHAVIOUR
//  Reset (Reset_n=0, async): bcd=0, blank={DIGITS-1{1},1'b0}, overflow=0, busy=0,
//   done=0, pending=0, FSM=IDLE, sync flops=0. Reset mid-conversion abandons it.
//   Outputs keep reset values until the next completed conversion.
//  frame_clk: 2-flop synchroniser plus edge register; rising edge yields one-cycle
//   req_f three Clks after the synchronised input goes high. req = req_f | start.
//  FSM IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
//   IDLE: if (req | pending) -> LOAD; pending cleared.
//   LOAD: sat = (Score > 999999) ? 999999 : Score; ovf_w = (Score > 999999).
//     bin_sh <= sat, work <= 0, cnt <= 0 -> SHIFT.
//     Score is sampled in the LOAD cycle only.
//   SHIFT: each work digit >= 5 gets +3 (4-bit add, no carry out).
//     Then {work,bin_sh} <<= 1; cnt++.
//     After the shift at cnt == SCORE_W-1 -> DONE. Exactly SCORE_W SHIFT cycles.
//   DONE: bcd <= work, overflow <= ovf_w, blank recomputed, done=1 for this cycle.
//     -> IDLE.
//  Latency: request accepted in IDLE -> done asserted SCORE_W+2 cycles later (22).
//   Outputs are registered and change only in DONE.
//  busy = 1 in LOAD, SHIFT and DONE.
//  req while busy sets pending (1-deep, coalescing). Any number of requests
//   during a conversion produce exactly one follow-up conversion.
//   That conversion uses Score as sampled in its own LOAD cycle.
//  req in the DONE cycle also sets pending. IDLE consumes pending the next cycle.
//  start and req_f in the same cycle count as a single request.
//  blank[i] = (digit i == 0) && all higher digits zero, for i >= 1.
//   blank[0] is always 0, so zero displays as a single "0".
//  Width rules: work is 4*DIGITS bits, bin_sh is SCORE_W bits, cnt is
//   $clog2(SCORE_W) bits. The compare against 999999 is SCORE_W-bit unsigned.
// TESTING
//  T1 Score=0, start pulse -> 22 cycles later: done=1, bcd=24'h000000,
//     blank=6'b111110, overflow=0.
//  T2 Score=123456, start -> bcd=24'h123456, blank=6'b000000, overflow=0.
//     busy high for exactly 22 cycles.
//  T3 Score=20'hFFFFF (1048575) -> bcd=24'h999999, overflow=1.
//     Then Score=42 -> bcd=24'h000042, blank=6'b111100, overflow=0.
//  T4 start at cycle 0, then start at cycles 5 and 10, with Score changed to 7 at
//     cycle 8 -> exactly two done pulses: first shows original Score, second = 7.
//  T5 frame_clk toggled asynchronously (period ~16.7 ms scaled down) with Score
//     ramping -> one done per rising edge, bcd matches Score sampled at LOAD.
//     Fails if there is a double-trigger on a single edge.
//  T6 Reset_n low mid-SHIFT (cycle 10), Score=999 -> outputs at reset values at
//     once, no done. After release + start: bcd=24'h000999, blank=6'b111000.

Source files
------------

// File: rtl/score_bcd_display.sv
// Sequential shift-add-3 binary-to-BCD converter for the game score display.
// Produces saturated BCD digits, a leading-zero blank mask and an overflow flag.
module score_bcd_display #(
    parameter int unsigned SCORE_W = 20,
    parameter int unsigned DIGITS  = 6
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  frame_clk,
    input  logic                  start,
    input  logic [SCORE_W-1:0]    Score,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  overflow,
    output logic                  busy,
    output logic                  done
);

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned p;
        p = 1;
        for (int unsigned k = 0; k < n; k++) p = p * 10;
        return p;
    endfunction

    localparam int unsigned BCD_W   = 4 * DIGITS;
    localparam int unsigned CNT_W   = $clog2(SCORE_W);
    localparam int unsigned MAX_VAL = pow10(DIGITS) - 1;
    localparam int unsigned ALL_W   = BCD_W + SCORE_W;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t               state, next_state;
    logic [1:0]           sync_q;
    logic                 sync_prev;
    logic                 req_f;
    logic                 req;
    logic                 pending;
    logic                 load_en, shift_en, finish;
    logic [BCD_W-1:0]     work, work_adj, work_nxt;
    logic [SCORE_W-1:0]   bin_sh, bin_nxt, sat;
    logic [CNT_W-1:0]     cnt;
    logic                 over, ovf_q;
    logic [ALL_W-1:0]     shifted;
    logic [DIGITS-1:0]    blank_nxt;

    // frame_clk synchroniser and rising-edge detector
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
            req_f     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], frame_clk};
            sync_prev <= sync_q[1];
            req_f     <= sync_q[1] & ~sync_prev;
        end
    end

    assign req  = req_f | start;
    assign over = Score > SCORE_W'(MAX_VAL);
    assign sat  = over ? SCORE_W'(MAX_VAL) : Score;

    // add-3 correction, then one shift of the combined register
    always_comb begin
        logic [3:0] d;
        d        = '0;
        work_adj = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            d = work[4*i +: 4];
            work_adj[4*i +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
        end
        shifted  = {work_adj, bin_sh} << 1;
        work_nxt = shifted[ALL_W-1 -: BCD_W];
        bin_nxt  = shifted[SCORE_W-1:0];
    end

    // a digit is blank when it and every higher digit are zero; units never blank
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank_nxt  = '0;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            zero_above   = zero_above & (work_nxt[4*i +: 4] == 4'd0);
            blank_nxt[i] = zero_above;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        load_en    = 1'b0;
        shift_en   = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE:  if (req || pending) next_state = LOAD;
            LOAD:  begin
                load_en    = 1'b1;
                next_state = SHIFT;
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt == CNT_W'(SCORE_W - 1)) begin
                    finish     = 1'b1;
                    next_state = DONE;
                end
            end
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // 1-deep coalescing request memory for requests arriving while busy
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)           pending <= 1'b0;
        else if (state == IDLE) pending <= 1'b0;
        else if (req)           pending <= 1'b1;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            work   <= '0;
            bin_sh <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
        end else if (load_en) begin
            work   <= '0;
            bin_sh <= sat;
            cnt    <= '0;
            ovf_q  <= over;
        end else if (shift_en) begin
            work   <= work_nxt;
            bin_sh <= bin_nxt;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // results land together with done, so they are visible throughout DONE
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bcd      <= '0;
            blank    <= {{(DIGITS-1){1'b1}}, 1'b0};
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= finish;
            busy <= (next_state != IDLE);
            if (finish) begin
                bcd      <= work_nxt;
                blank    <= blank_nxt;
                overflow <= ovf_q;
            end
        end
    end

endmodule
